// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, constants and
// the decode-facing entry layout.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int INSN_W       = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSN_W-1:0]       ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: prefetch buffer, power-of-two FIFO with wrap-around pointers and flush.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk_i/rst_i (async active-high), push_i/push_dat_i, pop_i, flush_i,
//        head_dat_o, full_o, empty_o, count_o (occupancy, $clog2(DEPTH)+1 bits).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [W-1:0]           head_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so push on full is fine alongside it.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch with prefetch buffer, in-order response tracking and redirect.
// Latency: response to dec_valid is one cycle; first dec_valid two cycles after first acceptance.
// Backpressure: requests stop once buffer occupancy + outstanding reaches DEPTH.
// Ports: CLOCK_50, reset (async active-high); imem_req_valid/ready, imem_addr;
//        imem_rsp_valid/data; dec_valid/ready, dec_ins, dec_pc; redirect_valid/pc;
//        misalign_trap only when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INSN_W-1:0] dec_ins,
  output logic [XLEN-1:0]   dec_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              misalign_trap
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INSN_W;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;   // PC of the next response that will be kept
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   occ;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] target;
  logic [EW-1:0]   head;
  logic            trapped;
  logic            req_fire, rsp_ok, rsp_keep, pop, buf_full, buf_empty;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign target        = redirect_pc;
  assign trapped       = trap_q;
  assign misalign_trap = trap_q;
  assign trap_d        = trap_q || (redirect_valid && (redirect_pc[1:0] != 2'b00));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end
`else
  logic unused_redirect_lsb;
  assign target              = {redirect_pc[XLEN-1:2], 2'b00};
  assign trapped             = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  assign inflight = {1'b0, occ} + {1'b0, outst_q};

  // Gated by reset so the request line is low while reset is held, not only after an edge.
  assign imem_req_valid = !reset && !redirect_valid && !trapped &&
                          (inflight < (CW + 1)'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // With nothing outstanding a response is a leftover from before reset; ignore it.
  assign rsp_ok   = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_ok && (discard_q == '0) && !redirect_valid && !trapped &&
                    (!buf_full || pop);
  assign pop      = dec_valid && dec_ready;

  always_comb begin
    outst_d = outst_q;
    if (req_fire && !rsp_ok && (outst_q != CW'(DEPTH))) outst_d = outst_q + CW'(1);
    else if (rsp_ok && !req_fire)                       outst_d = outst_q - CW'(1);

    // On redirect every request still in flight after this edge is stale; a response
    // landing in the redirect cycle is already excluded from outst_d.
    discard_d = discard_q;
    if (redirect_valid)                    discard_d = outst_d;
    else if (rsp_ok && (discard_q != '0))  discard_d = discard_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = target;
    else if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);

    // Responses are in order and every pre-redirect one is discarded, so kept
    // responses map onto consecutive PCs from the last redirect target.
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) rsp_pc_d = target;
    else if (rsp_keep)  rsp_pc_d = rsp_pc_q + XLEN'(4);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_buf (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .push_i     (rsp_keep),
    .push_dat_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_dat_o (head),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .count_o    (occ)
  );

  assign dec_valid = !buf_empty;
  assign dec_pc    = head[EW-1:INSN_W];
  assign dec_ins   = head[INSN_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, scoreboarded
// against a model of the expected decode stream (consecutive PCs from the last
// reset/redirect target, each carrying the memory word for that address).
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_ins, dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_ins        (dec_ins),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSN;
  endfunction

  // Reference model: expected decode stream and expected next fetch address.
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_fetch_pc;

  task automatic restart_model(input logic [31:0] start);
    fetch_entry_t e;
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      e.pc  = start + 32'(4 * k);
      e.ins = ins_of(e.pc);
      exp_q.push_back(e);
    end
    exp_fetch_pc = start;
  endtask

  // Memory model: in-order responses, at least one cycle after acceptance.
  logic [31:0] pend_q[$];
  bit mem_hold = 1'b0, mem_rand = 1'b0, keep_stale = 1'b0;

  initial begin
    bit acc, rsp_now, rst_now;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc     = imem_req_valid && imem_req_ready;
      a       = imem_addr;
      rsp_now = imem_rsp_valid;
      rst_now = reset;
      @(posedge clk);
      #2;
      if (rsp_now && pend_q.size() > 0) void'(pend_q.pop_front());
      if (rst_now && !keep_stale) pend_q.delete();
      if (acc) pend_q.push_back(a);
      if (pend_q.size() > 0 && !mem_hold && (!mem_rand || $urandom_range(0, 99) < 60)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ins_of(pend_q[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every decode handshake, tracks fetch addresses.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (redirect_valid) check("req_low_in_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid) begin
          check("imem_addr", imem_addr, exp_fetch_pc);
          if (imem_req_ready) exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (dec_valid && dec_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dec_unexpected: got pc %h, expected no delivery", dec_pc);
          end else begin
            e = exp_q.pop_front();
            check("dec_pc", dec_pc, e.pc);
            check("dec_ins", dec_ins, e.ins);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    restart_model(RV);
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick;
    redirect_valid = 1'b0;
    restart_model({pc[31:2], 2'b00});
  endtask

  task automatic wait_dec(output logic [31:0] pc);
    pc = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dec_valid && dec_ready) begin
        pc = dec_pc;
        break;
      end
    end
    tick;
  endtask

  task automatic count_accepts(input int limit, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) n++;
      if (limit > 0 && n == limit) break;
    end
    tick;
  endtask

  int          n, first_acc, first_dec, k;
  logic [31:0] pc, first_pc, a0, a1, tgt;

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart_model(RV);
    repeat (2) tick;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_imem_addr", imem_addr, RV);
    tick;

    // Release, always-ready memory with one-cycle responses
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    reset          = 1'b0;
    first_acc = -1;
    first_dec = -1;
    first_pc  = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && first_acc < 0) first_acc = i;
      if (dec_valid && first_dec < 0) begin
        first_dec = i;
        first_pc  = dec_pc;
      end
    end
    tick;
    check("first_dec_latency", 32'(first_dec - first_acc), 32'd2);
    check("first_dec_pc", first_pc, RV);

    // Decode stalled: buffer + outstanding caps requests at DEPTH
    dec_ready = 1'b0;
    do_reset();
    count_accepts(0, 20, n);
    check("accepts_while_stalled", 32'(n), 32'(DEPTH));
    @(negedge clk);
    check("req_low_when_full", 32'(imem_req_valid), 32'd0);
    tick;
    dec_ready = 1'b1;
    tick;
    dec_ready = 1'b0;
    @(negedge clk);
    check("req_after_pop", 32'(imem_req_valid), 32'd1);
    tick;
    dec_ready = 1'b1;
    repeat (10) tick;

    // Redirect with two responses outstanding, one returning in the redirect cycle
    mem_hold = 1'b1;
    do_reset();
    count_accepts(2, 20, n);
    check("two_outstanding", 32'(n), 32'd2);
    imem_req_ready = 1'b0;
    tick;
    mem_hold = 1'b0;
    redirect(32'h0000_0100);
    imem_req_ready = 1'b1;
    wait_dec(pc);
    check("redirect_first_pc", pc, 32'h0000_0100);

    // Back-to-back redirects with three outstanding
    mem_hold = 1'b1;
    do_reset();
    count_accepts(3, 20, n);
    check("three_outstanding", 32'(n), 32'd3);
    imem_req_ready = 1'b0;
    tick;
    mem_hold = 1'b0;
    redirect(32'h0000_0200);
    redirect(32'h0000_0300);
    imem_req_ready = 1'b1;
    wait_dec(pc);
    check("b2b_redirect_first_pc", pc, 32'h0000_0300);

    // Fetch address wraps at 2^32
    redirect(32'hFFFF_FFFC);
    k  = 0;
    a0 = 'x;
    a1 = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        if (k == 0) a0 = imem_addr;
        else if (k == 1) a1 = imem_addr;
        k++;
      end
    end
    tick;
    check("wrap_addr0", a0, 32'hFFFF_FFFC);
    check("wrap_addr1", a1, 32'h0000_0000);

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick;
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("trap_set", 32'(misalign_trap), 32'd1);
      check("trap_req_low", 32'(imem_req_valid), 32'd0);
      check("trap_buf_empty", 32'(dec_valid), 32'd0);
    end
    tick;
    do_reset();
    @(negedge clk);
    check("trap_cleared", 32'(misalign_trap), 32'd0);
    tick;
`else
    redirect(32'h0000_0102);
    wait_dec(pc);
    check("misaligned_forced", pc, 32'h0000_0100);
`endif

    // Randomized traffic with random redirects and one mid-flight reset
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        keep_stale = 1'b1;
        mem_rand   = 1'b0;
        #1;
        reset = 1'b1;
        restart_model(RV);
        #1;
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
        check("async_rst_imem_addr", imem_addr, RV);
        repeat (2) tick;
        imem_req_ready = 1'b0;
        reset          = 1'b0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          check("stale_dec_valid", 32'(dec_valid), 32'd0);
        end
        tick;
        keep_stale = 1'b0;
        mem_rand   = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
        redirect(tgt);
      end else begin
        tick;
      end
    end

    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    repeat (20) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: width of PC and address paths.
REQ-002 Parameter DEPTH, default 4: prefetch buffer entries, power of two, 2..16.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-004 CLOCK_50  in  1: single clock; all state updates on its rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 imem_req_valid  out  1: fetch request pending.
REQ-007 imem_req_ready  in  1: memory accepts the request this cycle.
REQ-008 imem_addr  out  XLEN: fetch address, equal to fetch_pc.
REQ-009 imem_rsp_valid  in  1: instruction word returned; responses arrive in request order.
REQ-010 imem_rsp_data  in  32: returned instruction word.
REQ-011 dec_valid  out  1: head buffer entry available to decode.
REQ-012 dec_ready  in  1: decode consumes the head entry.
REQ-013 dec_ins  out  32: instruction at the buffer head.
REQ-014 dec_pc  out  XLEN: PC of dec_ins.
REQ-015 redirect_valid  in  1: branch or jump taken; a new PC is supplied.
REQ-016 redirect_pc  in  XLEN: branch or jump target.

Function
REQ-017 A request is accepted when imem_req_valid && imem_req_ready; on acceptance fetch_pc advances by 4, modulo 2^XLEN.
REQ-018 imem_req_valid is high only while (buffer occupancy + outstanding) < DEPTH, so an accepted response never overflows the buffer.
REQ-019 outstanding increments on each accepted request and decrements on each imem_rsp_valid; it is never driven below 0 or above DEPTH.
REQ-020 A non-discarded response is written into the buffer together with its request PC; dec_valid rises on the next cycle, giving one cycle of latency.
REQ-021 Buffer behaviour: FIFO with wrap-around pointers; dec_valid = !empty; a pop happens on dec_valid && dec_ready; a push and a pop in the same cycle leave occupancy unchanged; a pop and a push on a full buffer is legal.
REQ-022 Redirect, effective at the clock edge in the cycle where redirect_valid is high:
  - buffer flushed;
  - fetch_pc set to redirect_pc;
  - discard_cnt set to the outstanding count, including any request accepted in that same cycle;
  - imem_req_valid is low in the redirect cycle.
REQ-023 A decode handshake that completes in the redirect cycle counts as delivered.
REQ-024 While discard_cnt > 0, each response is dropped (not written to the buffer) and discard_cnt decrements.
REQ-025 A response arriving in the redirect cycle is itself dropped and is not counted into discard_cnt.
REQ-026 A second redirect before all discards finish recomputes discard_cnt from the current outstanding count; all stale responses are dropped.
REQ-027 Counters are clog2(DEPTH)+1 bits wide and saturate safely at DEPTH.

Reset
REQ-028 On reset assertion, without waiting for a clock: fetch_pc=RESET_VECTOR, buffer empty, outstanding=0, discard_cnt=0, dec_valid=0, imem_req_valid=0.
REQ-029 imem_req_valid may first assert in the first cycle after reset deasserts; at that point imem_addr=RESET_VECTOR.
REQ-030 Reset asserted mid-operation abandons in-flight requests; no response arriving after release is accepted as data until a new request is issued.

Configuration
REQ-031 Feature macro FETCH_MISALIGN_TRAP_EN.
REQ-032 With FETCH_MISALIGN_TRAP_EN defined:
  - output misalign_trap (out, 1) is present;
  - a redirect_pc with bits [1:0] != 0 sets misalign_trap, which is sticky until reset;
  - after the trap, no further requests are issued and the buffer stays empty.
REQ-033 Without FETCH_MISALIGN_TRAP_EN, the misalign_trap port is absent and redirect_pc[1:0] is forced to 0.

Structure
REQ-034 Shared package fetch_pkg holds:
  - INSN_W=32;
  - the default XLEN;
  - the RISC-V NOP constant 32'h0000_0013;
  - typedef fetch_entry_t {pc[XLEN-1:0], ins[31:0]}.
REQ-035 The buffer is a sub-module, fetch_fifo, parameterised by DEPTH, with push, pop, flush, full, empty and count.

Verification
REQ-036 Reset release, imem_req_ready=1, single-cycle responses -> requests at 0x0,0x4,0x8; the first dec_valid is two cycles after the first acceptance, with dec_pc=0x0.
REQ-037 dec_ready=0 with DEPTH=4 -> exactly 4 requests are accepted, then imem_req_valid=0 until the first pop.
REQ-038 Redirect to 0x100 with 2 responses outstanding -> both responses are dropped, and the next dec_pc=0x100.
REQ-039 Back-to-back redirects to 0x200 then 0x300 with 3 outstanding -> no 0x2xx or stale PC ever reaches decode; the next dec_pc=0x300.
REQ-040 fetch_pc=0xFFFF_FFFC with a request accepted -> the next imem_addr=0x0000_0000.
REQ-041 FETCH_MISALIGN_TRAP_EN defined, redirect_pc=0x102 -> misalign_trap=1 and imem_req_valid stays 0.
